// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   state_e      : arbiter FSM states
//   half_kind_e  : how a 2-bit byte-enable pair maps onto one 16-bit RAM half
//   dmem_req_t   : request payload as seen by the arbiter
package dmem_arb_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_LDR  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HALF_NONE    = 2'd0,
    HALF_FULL    = 2'd1,
    HALF_PARTIAL = 2'd2
  } half_kind_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // A half can be written directly only when both of its bytes are enabled.
  function automatic half_kind_e half_kind(input logic [1:0] be);
    case (be)
      2'b00:   half_kind = HALF_NONE;
      2'b11:   half_kind = HALF_FULL;
      default: half_kind = HALF_PARTIAL;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way arbiter with round-robin or fixed (port 0) priority.
//   clk, rst_n : clock, async active-low reset
//   i_valid    : per-port request valid (already qualified by the caller)
//   i_accept   : a granted request was accepted this cycle
//   o_gnt      : one-hot grant, zero when nothing is valid
//   o_ptr      : port holding priority on the next contested cycle
module dmem_rr_arb2 #(
  parameter int unsigned RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_ptr
);

  logic r_ptr;

  // Contention goes to the pointer port (round-robin) or always port 0.
  always_comb begin
    o_gnt = i_valid;
    if (i_valid == 2'b11) begin
      o_gnt = ((RR_EN != 0) && r_ptr) ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other port takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_gnt[0];
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory (two 128x16 macros, lo/hi halves) between
// the core LSU (port 0) and the loader/debug port (port 1). Byte/halfword
// stores that split a 16-bit half are done as read-modify-write.
//   clk, rst_n          : clock, async active-low reset
//   reqN_*              : request handshake and payload (N = 0, 1)
//   rspN_valid/rdata    : one-cycle response pulse, load data (0 for stores)
//   ram_cen_n/wen_*_n   : macro chip/write enables, active low
//   ram_addr/ram_d/ram_q: macro word address, write data, read data
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [31:0]       req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [3:0]        req0_be,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [31:0]       req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [3:0]        req1_be,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              ram_cen_n,
  output logic              ram_wen_lo_n,
  output logic              ram_wen_hi_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_d,
  input  logic [31:0]       ram_q
);

  state_e            r_state;
  state_e            w_next;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;

  logic              w_idle;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel;
  logic              w_rr_ptr;
  dmem_req_t         w_req0;
  dmem_req_t         w_req1;
  dmem_req_t         w_req;
  logic [ADDR_W-1:0] w_req_waddr;
  half_kind_e        w_lo_kind;
  half_kind_e        w_hi_kind;
  logic [31:0]       w_merged;
  logic              w_unused;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign w_idle = (r_state == IDLE) && rst_n;

  dmem_rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({req1_valid, req0_valid} & {2{w_idle}}),
    .i_accept(w_accept),
    .o_gnt   (w_gnt),
    .o_ptr   (w_rr_ptr)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_accept   = |w_gnt;
  assign w_sel      = w_gnt[1];

  assign w_req0      = {req0_we, req0_addr, req0_wdata, req0_be};
  assign w_req1      = {req1_we, req1_addr, req1_wdata, req1_be};
  assign w_req       = w_sel ? w_req1 : w_req0;
  assign w_req_waddr = w_req.addr[ADDR_W+1:2];
  assign w_lo_kind   = half_kind(w_req.be[1:0]);
  assign w_hi_kind   = half_kind(w_req.be[3:2]);

  // Address bits outside the word index alias and are intentionally dropped.
  assign w_unused = ^{req0_addr[31:ADDR_W+2], req0_addr[1:0],
                      req1_addr[31:ADDR_W+2], req1_addr[1:0], w_rr_ptr};

  // Enabled bytes from the stored request, the rest from the RAM read.
  always_comb begin
    w_merged = ram_q;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request context kept for the response and the RMW write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_port  <= w_sel;
      r_we    <= w_req.we;
      r_addr  <= w_req_waddr;
      r_wdata <= w_req.wdata;
      r_be    <= w_req.be;
    end
  end

  // Next state, RAM pin drive and response outputs.
  always_comb begin
    w_next       = r_state;
    ram_cen_n    = 1'b1;
    ram_wen_lo_n = 1'b1;
    ram_wen_hi_n = 1'b1;
    ram_addr     = '0;
    ram_d        = '0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_rdata   = '0;
    rsp1_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = RESP;
          if (!w_req.we) begin
            ram_cen_n = 1'b0;
            ram_addr  = w_req_waddr;
          end else if ((w_lo_kind == HALF_PARTIAL) || (w_hi_kind == HALF_PARTIAL)) begin
            // Read the word now; merge and write it back next cycle.
            ram_cen_n = 1'b0;
            ram_addr  = w_req_waddr;
            w_next    = RMW_WR;
          end else if (w_req.be != 4'b0000) begin
            ram_cen_n    = 1'b0;
            ram_addr     = w_req_waddr;
            ram_wen_lo_n = (w_lo_kind != HALF_FULL);
            ram_wen_hi_n = (w_hi_kind != HALF_FULL);
            ram_d        = w_req.wdata;
          end
        end
      end
      RMW_WR: begin
        ram_cen_n    = 1'b0;
        ram_addr     = r_addr;
        ram_wen_lo_n = ~|r_be[1:0];
        ram_wen_hi_n = ~|r_be[3:2];
        ram_d        = w_merged;
        w_next       = RESP;
      end
      RESP: begin
        w_next = IDLE;
        if (r_port) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = r_we ? '0 : ram_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = r_we ? '0 : ram_q;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance A (round-robin) with a
// behavioural 2x128x16 RAM, instance B (fixed priority) with an address-echo RAM.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A stimulus/observation
  logic [1:0]  a_valid;
  logic        a_we   [2];
  logic [31:0] a_addr [2];
  logic [31:0] a_wdata[2];
  logic [3:0]  a_be   [2];
  logic        a_rdy0, a_rdy1, a_rv0, a_rv1;
  logic [31:0] a_rd0, a_rd1;
  logic        a_cen_n, a_wen_lo_n, a_wen_hi_n;
  logic [6:0]  a_ram_addr;
  logic [31:0] a_ram_d, a_ram_q;

  // Instance B (RR_EN=0)
  logic [1:0]  b_valid;
  logic        b_rdy0, b_rdy1, b_rv0, b_rv1;
  logic [31:0] b_rd0, b_rd1;
  logic        b_cen_n, b_wen_lo_n, b_wen_hi_n;
  logic [6:0]  b_ram_addr;
  logic [31:0] b_ram_d, b_ram_q;

  dmem_port_arbiter #(.ADDR_W(7), .RR_EN(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_valid[0]), .req0_ready(a_rdy0), .req0_we(a_we[0]), .req0_addr(a_addr[0]),
    .req0_wdata(a_wdata[0]), .req0_be(a_be[0]), .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0),
    .req1_valid(a_valid[1]), .req1_ready(a_rdy1), .req1_we(a_we[1]), .req1_addr(a_addr[1]),
    .req1_wdata(a_wdata[1]), .req1_be(a_be[1]), .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1),
    .ram_cen_n(a_cen_n), .ram_wen_lo_n(a_wen_lo_n), .ram_wen_hi_n(a_wen_hi_n),
    .ram_addr(a_ram_addr), .ram_d(a_ram_d), .ram_q(a_ram_q)
  );

  dmem_port_arbiter #(.ADDR_W(7), .RR_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_valid[0]), .req0_ready(b_rdy0), .req0_we(1'b0), .req0_addr(32'h0000_0010),
    .req0_wdata(32'h0), .req0_be(4'h0), .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0),
    .req1_valid(b_valid[1]), .req1_ready(b_rdy1), .req1_we(1'b0), .req1_addr(32'h0000_0020),
    .req1_wdata(32'h0), .req1_be(4'h0), .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1),
    .ram_cen_n(b_cen_n), .ram_wen_lo_n(b_wen_lo_n), .ram_wen_hi_n(b_wen_hi_n),
    .ram_addr(b_ram_addr), .ram_d(b_ram_d), .ram_q(b_ram_q)
  );

  // Behavioural macros: write per half, registered read.
  logic [15:0] mem_lo[128];
  logic [15:0] mem_hi[128];
  always_ff @(posedge clk) begin
    if (!a_cen_n) begin
      if (!a_wen_lo_n) mem_lo[a_ram_addr] <= a_ram_d[15:0];
      if (!a_wen_hi_n) mem_hi[a_ram_addr] <= a_ram_d[31:16];
      a_ram_q <= {mem_hi[a_ram_addr], mem_lo[a_ram_addr]};
    end
  end

  // Instance B RAM returns its own word address.
  always_ff @(posedge clk) begin
    if (!b_cen_n) b_ram_q <= {25'd0, b_ram_addr};
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? a_rdy1 : a_rdy0;
  endfunction
  function automatic logic rv(input int p);
    return (p == 1) ? a_rv1 : a_rv0;
  endfunction
  function automatic logic [31:0] rd(input int p);
    return (p == 1) ? a_rd1 : a_rd0;
  endfunction

  // Per-transfer observations
  logic        acc_cen, acc_wlo, acc_whi;
  logic [6:0]  acc_addr;
  logic [31:0] acc_d;
  int          wr_cnt;
  logic        wr_lo, wr_hi;
  logic [31:0] wr_d;
  bit          seen_cen0;
  int          spur;

  task automatic mon(input int p);
    if (!a_cen_n) seen_cen0 = 1'b1;
    if (!a_cen_n && (!a_wen_lo_n || !a_wen_hi_n)) begin
      wr_cnt++;
      wr_lo = a_wen_lo_n;
      wr_hi = a_wen_hi_n;
      wr_d  = a_ram_d;
    end
    if (rv(1 - p)) spur++;
  endtask

  // One request on port p; checks acceptance, latency, rdata, no stray response.
  task automatic xfer(input string tag, input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int exp_lat, input logic [31:0] exp_rd);
    bit acc;
    int lat;
    logic [31:0] rdv;
    acc = 1'b0; lat = 0; rdv = '0;
    @(posedge clk); #1;
    a_we[p] = we; a_addr[p] = addr; a_wdata[p] = wd; a_be[p] = be; a_valid[p] = 1'b1;
    seen_cen0 = 1'b0; wr_cnt = 0; spur = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mon(p);
      if (rdy(p)) begin
        acc = 1'b1;
        acc_cen = a_cen_n; acc_wlo = a_wen_lo_n; acc_whi = a_wen_hi_n;
        acc_addr = a_ram_addr; acc_d = a_ram_d;
        break;
      end
    end
    chk({tag, ".acc"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    a_valid[p] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      mon(p);
      if (rv(p)) begin
        lat = i;
        rdv = rd(p);
        break;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, rdv, we ? 32'h0 : exp_rd);
    chk({tag, ".spur"}, 32'(spur), 32'd0);
  endtask

  initial begin
    int gseq[16];
    int ng, rem0, rem1, nr0, nr1, g, both, b_odd, norsp;

    // 1: reset values, ready gated while reset is held
    rst_n = 1'b0;
    a_valid = 2'b01; b_valid = 2'b00;
    for (int p = 0; p < 2; p++) begin
      a_we[p] = 1'b0; a_addr[p] = 32'h0; a_wdata[p] = 32'h0; a_be[p] = 4'h0;
    end
    repeat (2) @(negedge clk);
    chk("rst.rdy0", 32'(a_rdy0), 32'd0);
    chk("rst.rdy1", 32'(a_rdy1), 32'd0);
    chk("rst.rsp", 32'({a_rv1, a_rv0}), 32'd0);
    chk("rst.rdata0", a_rd0, 32'h0);
    chk("rst.rdata1", a_rd1, 32'h0);
    chk("rst.pins", 32'({a_cen_n, a_wen_lo_n, a_wen_hi_n}), 32'd7);
    chk("rst.addr", 32'(a_ram_addr), 32'd0);
    chk("rst.d", a_ram_d, 32'h0);
    a_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    seen_cen0 = 1'b0; spur = 0;
    repeat (4) begin @(negedge clk); mon(0); end
    chk("idle.cen", 32'(seen_cen0), 32'd0);

    // 2: full store then load
    xfer("st_full", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1, 32'h0);
    chk("st_full.pins", 32'({acc_cen, acc_wlo, acc_whi}), 32'd0);
    chk("st_full.addr", 32'(acc_addr), 32'd4);
    chk("st_full.d", acc_d, 32'hDEAD_BEEF);
    xfer("ld_10", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hDEAD_BEEF);

    // 3: read-modify-write byte stores
    xfer("st_20", 0, 1'b1, 32'h20, 32'h1122_3344, 4'b1111, 1, 32'h0);
    xfer("rmw_b2", 1, 1'b1, 32'h20, 32'h00AA_0000, 4'b0100, 2, 32'h0);
    chk("rmw_b2.rd_pins", 32'({acc_cen, acc_wlo, acc_whi}), 32'b011);
    chk("rmw_b2.wr_cnt", 32'(wr_cnt), 32'd1);
    chk("rmw_b2.wr_wen", 32'({wr_lo, wr_hi}), 32'b10);
    chk("rmw_b2.wr_d", wr_d, 32'h11AA_3344);
    xfer("ld_20a", 1, 1'b0, 32'h20, 32'h0, 4'h0, 1, 32'h11AA_3344);
    xfer("rmw_b0", 0, 1'b1, 32'h20, 32'h0000_00FF, 4'b0001, 2, 32'h0);
    chk("rmw_b0.wr_wen", 32'({wr_lo, wr_hi}), 32'b01);
    xfer("rmw_b31", 0, 1'b1, 32'h20, 32'hCC00_DD00, 4'b1010, 2, 32'h0);
    chk("rmw_b31.wr_wen", 32'({wr_lo, wr_hi}), 32'b00);
    chk("rmw_b31.wr_d", wr_d, 32'hCCAA_DDFF);
    // Upper address bits alias onto the same word
    xfer("ld_alias", 1, 1'b0, 32'h0000_0220, 32'h0, 4'h0, 1, 32'hCCAA_DDFF);

    // 5: empty store, halfword store
    xfer("st_none", 0, 1'b1, 32'h10, 32'h1234_5678, 4'b0000, 1, 32'h0);
    chk("st_none.cen", 32'(seen_cen0), 32'd0);
    xfer("st_hw", 0, 1'b1, 32'h10, 32'hCAFE_0000, 4'b1100, 1, 32'h0);
    chk("st_hw.wr_cnt", 32'(wr_cnt), 32'd1);
    chk("st_hw.pins", 32'({acc_cen, acc_wlo, acc_whi}), 32'b010);
    xfer("ld_hw", 1, 1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hCAFE_BEEF);

    // 4a: round-robin, both ports loading continuously
    @(posedge clk); #1;
    a_we[0] = 1'b0; a_addr[0] = 32'h10;
    a_we[1] = 1'b0; a_addr[1] = 32'h20;
    a_valid = 2'b11;
    rem0 = 6; rem1 = 6; ng = 0; nr0 = 0; nr1 = 0; both = 0;
    for (int c = 0; c < 100 && (nr0 + nr1) < 12; c++) begin
      @(negedge clk);
      if (a_rv0) begin nr0++; chk("rr.rd0", a_rd0, 32'hCAFE_BEEF); end
      if (a_rv1) begin nr1++; chk("rr.rd1", a_rd1, 32'hCCAA_DDFF); end
      if (a_rdy0 && a_rdy1) both++;
      g = -1;
      if (a_rdy0) g = 0;
      else if (a_rdy1) g = 1;
      if (g >= 0 && ng < 16) begin gseq[ng] = g; ng++; end
      @(posedge clk); #1;
      if (g == 0) begin rem0--; if (rem0 == 0) a_valid[0] = 1'b0; end
      if (g == 1) begin rem1--; if (rem1 == 0) a_valid[1] = 1'b0; end
    end
    a_valid = 2'b00;
    chk("rr.ngrant", 32'(ng), 32'd12);
    chk("rr.both", 32'(both), 32'd0);
    for (int i = 0; i < 12; i++) chk($sformatf("rr.g%0d", i), 32'(gseq[i]), 32'(i % 2));
    chk("rr.nrsp0", 32'(nr0), 32'd6);
    chk("rr.nrsp1", 32'(nr1), 32'd6);

    // 4b: fixed priority on instance B
    @(posedge clk); #1;
    b_valid = 2'b11;
    rem0 = 3; rem1 = 2; ng = 0; nr0 = 0; nr1 = 0; b_odd = 0;
    for (int c = 0; c < 100 && (nr0 + nr1) < 5; c++) begin
      @(negedge clk);
      if (b_rv0) begin nr0++; chk("fp.rd0", b_rd0, 32'd4); end
      if (b_rv1) begin nr1++; chk("fp.rd1", b_rd1, 32'd8); end
      if (!b_wen_lo_n || !b_wen_hi_n || (b_ram_d != 32'h0)) b_odd++;
      g = -1;
      if (b_rdy0) g = 0;
      else if (b_rdy1) g = 1;
      if (g >= 0 && ng < 16) begin gseq[ng] = g; ng++; end
      @(posedge clk); #1;
      if (g == 0) begin rem0--; if (rem0 == 0) b_valid[0] = 1'b0; end
      if (g == 1) begin rem1--; if (rem1 == 0) b_valid[1] = 1'b0; end
    end
    b_valid = 2'b00;
    chk("fp.ngrant", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("fp.g%0d", i), 32'(gseq[i]), (i < 3) ? 32'd0 : 32'd1);
    chk("fp.nrsp", 32'({nr0[15:0], nr1[15:0]}), {16'd3, 16'd2});
    chk("fp.no_write", 32'(b_odd), 32'd0);

    // 6: reset during the RMW write cycle
    xfer("st_30", 0, 1'b1, 32'h30, 32'h5566_7788, 4'b1111, 1, 32'h0);
    @(posedge clk); #1;
    a_we[0] = 1'b1; a_addr[0] = 32'h30; a_wdata[0] = 32'h0000_AB00; a_be[0] = 4'b0010;
    a_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst6.acc", 32'(a_rdy0), 32'd1);
    @(posedge clk); #1;
    a_valid[0] = 1'b0;
    chk("rst6.in_wr", 32'({a_cen_n, a_wen_lo_n}), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst6.pins", 32'({a_cen_n, a_wen_lo_n, a_wen_hi_n}), 32'd7);
    norsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_rv0 || a_rv1) norsp++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (a_rv0 || a_rv1) norsp++;
    end
    chk("rst6.no_rsp", 32'(norsp), 32'd0);
    xfer("rst6.ld", 1, 1'b0, 32'h30, 32'h0, 4'h0, 1, 32'h5566_7788);
    xfer("rst6.ld0", 0, 1'b0, 32'h20, 32'h0, 4'h0, 1, 32'hCCAA_DDFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
